modulo_arbitro_rr4: RTL and testbench

MODULO_ARBITRO_RR4 -- requirements
Module: modulo_arbitro_rr4

---
 rtl/modulo_arbitro_rr4.sv | 107 ++++++++++
 tb/tb_modulo_arbitro_rr4.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/modulo_arbitro_rr4.sv
// Four-way round-robin arbiter with hold limit, driving a 4:1 mux select.
// Ports: clk, rst (sync, high), req[3:0] in; gnt[3:0], input_sel[1:0], busy out.
module modulo_arbitro_rr4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] input_sel,
  output logic       busy
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hc_q, hc_d;
  logic [3:0] others;
  logic [3:0] gnt_d;
  logic [1:0] sel_d;
  logic       busy_d;

  // First requester after base, wrapping; base itself is tried last.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] base,
    input logic [3:0] r
  );
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign others = req & ~(4'b0001 << owner_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hc_d    = hc_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          owner_d = rr_pick(ptr_q, req);
          hc_d    = 8'd1;
        end
      end
      GRANT: begin
        // Release, or preempt a saturated owner when someone else waits.
        if (!req[owner_q] || (hc_q == HOLD_MAX && |others)) begin
          ptr_d = owner_q;
          if (|others) begin
            owner_d = rr_pick(owner_q, others);
            hc_d    = 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else if (hc_q != HOLD_MAX) begin
          hc_d = hc_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = 4'b0000;
    busy_d = 1'b0;
    sel_d  = input_sel;
    if (state_d == GRANT) begin
      gnt_d  = 4'b0001 << owner_d;
      busy_d = 1'b1;
      sel_d  = owner_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd3;
      hc_q      <= 8'd0;
      gnt       <= 4'b0000;
      busy      <= 1'b0;
      input_sel <= 2'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hc_q      <= hc_d;
      gnt       <= gnt_d;
      busy      <= busy_d;
      input_sel <= sel_d;
    end
  end

endmodule

// File: tb/tb_modulo_arbitro_rr4.sv
// Bench for modulo_arbitro_rr4: two instances (MAX_HOLD 8 and 1)
// against an integer reference model, directed scenarios then random.
module tb_modulo_arbitro_rr4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  int mh[2] = '{8, 1};
  int m_busy[2];
  int m_owner[2];
  int m_ptr[2];
  int m_hc[2];
  int m_sel[2];

  always #5 clk = ~clk;

  modulo_arbitro_rr4 #(.MAX_HOLD(8)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a), .input_sel(sel_a), .busy(busy_a)
  );

  modulo_arbitro_rr4 #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_b), .input_sel(sel_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int search(input int base, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(base + k) % 4]) return (base + k) % 4;
    return base;
  endfunction

  task automatic step_model(input int d, input bit r,
                            input logic [3:0] q);
    logic [3:0] oth;
    if (r) begin
      m_busy[d] = 0; m_sel[d] = 0; m_ptr[d] = 3; m_hc[d] = 0;
      m_owner[d] = 0;
    end else if (m_busy[d] == 0) begin
      if (q != 0) begin
        m_owner[d] = search(m_ptr[d], q);
        m_busy[d] = 1; m_hc[d] = 1; m_sel[d] = m_owner[d];
      end
    end else begin
      oth = q;
      oth[m_owner[d]] = 1'b0;
      if (!q[m_owner[d]] || (m_hc[d] >= mh[d] && oth != 0)) begin
        m_ptr[d] = m_owner[d];
        if (oth != 0) begin
          m_owner[d] = search(m_ptr[d], oth);
          m_hc[d] = 1; m_sel[d] = m_owner[d];
        end else begin
          m_busy[d] = 0;
        end
      end else if (m_hc[d] < mh[d]) begin
        m_hc[d] = m_hc[d] + 1;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int d);
    return m_busy[d] != 0 ? 4'(1 << m_owner[d]) : 4'b0000;
  endfunction

  task automatic cycle(input bit r, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    step_model(0, r, q);
    step_model(1, r, q);
    #1;
    chk("gnt8", gnt_a, exp_gnt(0));
    chk("sel8", sel_a, m_sel[0]);
    chk("busy8", busy_a, m_busy[0]);
    chk("gnt1", gnt_b, exp_gnt(1));
    chk("sel1", sel_b, m_sel[1]);
    chk("busy1", busy_b, m_busy[1]);
    chk("onehot8", $onehot0(gnt_a), 1);
    chk("onehot1", $onehot0(gnt_b), 1);
    chk("reqok8", gnt_a & ~q, 0);
    chk("reqok1", gnt_b & ~q, 0);
  endtask

  initial begin
    logic [3:0] q;
    for (int d = 0; d < 2; d++) step_model(d, 1'b1, 4'b0000);

    cycle(1'b1, 4'b1111);
    cycle(1'b1, 4'b0000);
    chk("rst_gnt", gnt_a, 4'b0000);
    chk("rst_sel", sel_a, 2'b00);

    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 4'b1111);
      if (i == 0)  chk("rot0", gnt_a, 4'b0001);
      if (i == 8)  chk("rot1", gnt_a, 4'b0010);
      if (i == 16) chk("rot2", gnt_a, 4'b0100);
      if (i == 24) chk("rot3", {sel_a, gnt_a}, 6'b11_1000);
    end

    cycle(1'b1, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 4'b0100);
      chk("alone", gnt_a, 4'b0100);
    end

    cycle(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0001);
    cycle(1'b0, 4'b1000);
    chk("handoff", {busy_a, gnt_a}, 5'b1_1000);

    cycle(1'b0, 4'b0100);
    cycle(1'b0, 4'b0100);
    cycle(1'b0, 4'b0000);
    chk("idle_sel", {busy_a, gnt_a, sel_a}, 7'b0_0000_10);
    cycle(1'b0, 4'b0101);
    chk("wrap", gnt_a, 4'b0001);

    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0010);
    cycle(1'b1, 4'b0010);
    chk("rst_mid", {gnt_a, sel_a}, 6'b0000_00);
    cycle(1'b0, 4'b0010);
    chk("resume", gnt_a, 4'b0010);

    cycle(1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 4'b0011);
      chk("alt1", gnt_b, (i % 2 == 0) ? 4'b0001 : 4'b0010);
    end

    q = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) q = 4'($urandom);
      if ($urandom_range(0, 9) == 0) q[$urandom_range(0, 3)] = 1'b0;
      cycle($urandom_range(0, 49) == 0, q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
